// File: rtl/spdif_pkg.sv
// Types shared across the S/PDIF receive path: lock-controller states and the half-bit bus width.
// Pure declarations; no logic, no latency, no backpressure.
package spdif_pkg;

    localparam int MAX_CLK_PER_HALFBIT_LOG2_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SETTLE       = 3'd1,
        ST_PROBE        = 3'd2,
        ST_LOCKED       = 3'd3,
        ST_RETRY_SETTLE = 3'd4,
        ST_RETRY_PROBE  = 3'd5
    } lock_state_t;

endpackage

// File: rtl/spdif_timer.sv
// Loadable down-counter that stops at zero; zero flag comes straight from the count register.
// Load takes effect on the next edge; no backpressure.
module spdif_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spdif_lock_ctrl.sv
// Hunts the receiver half-bit period (settle, probe, advance) and supervises the resulting lock.
// All outputs registered, one cycle after the deciding input; receiver cannot stall this block.
module spdif_lock_ctrl
    import spdif_pkg::*;
#(
    parameter int MAX_CLK_PER_HALFBIT_LOG2 = MAX_CLK_PER_HALFBIT_LOG2_DEF,
    parameter int CPH_MIN                  = 3,
    parameter int CPH_MAX                  = 31,
    parameter int TIMER_W                  = 16,
    parameter int SETTLE_CYCLES            = 4096,
    parameter int PROBE_CYCLES             = 16384,
    parameter int MIN_ACKS                 = 8,
    parameter int WATCHDOG_CYCLES          = 8192
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable_i,
    input  logic                                dai_locked_i,
    input  logic                                dai_ack_i,
    output logic [MAX_CLK_PER_HALFBIT_LOG2-1:0] clk_per_halfbit_o,
    output logic                                dai_rst_o,
    output logic                                lock_o,
    output logic                                scan_wrap_o,
    output logic                                relock_o
);

    localparam int W     = MAX_CLK_PER_HALFBIT_LOG2;
    localparam int ACK_W = $clog2(MIN_ACKS + 1);

    localparam logic [W-1:0]       CPH_LO    = W'(CPH_MIN);
    localparam logic [W-1:0]       CPH_HI    = W'(CPH_MAX);
    localparam logic [ACK_W-1:0]   ACK_SAT   = ACK_W'(MIN_ACKS);
    localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PROBE_LD  = TIMER_W'(PROBE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WDOG_LD   = TIMER_W'(WATCHDOG_CYCLES - 1);

    lock_state_t        state_q, state_d;
    logic [W-1:0]       cph_q, cph_d, cph_adv;
    logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d, ack_next;
    logic               dai_rst_q, dai_rst_d;
    logic               lock_q, lock_d;
    logic               scan_wrap_q, scan_wrap_d;
    logic               relock_q, relock_d;
    logic               at_max;
    logic               tmr_load, tmr_zero;
    logic [TIMER_W-1:0] tmr_val;

    spdif_timer #(
        .TIMER_W    (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign at_max   = (cph_q == CPH_HI);
    assign cph_adv  = at_max ? CPH_LO : cph_q + W'(1);
    // Ack-inclusive count so a pulse in the final probe cycle still counts toward the pass.
    assign ack_next = ack_cnt_q + ACK_W'(dai_ack_i && (ack_cnt_q != ACK_SAT));

    always_comb begin
        state_d     = state_q;
        cph_d       = cph_q;
        ack_cnt_d   = ack_cnt_q;
        scan_wrap_d = 1'b0;
        relock_d    = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        unique case (state_q)
            // Leave IDLE only once the reset-release cycle has dropped dai_rst.
            ST_IDLE: begin
                if (!dai_rst_q) begin
                    state_d = ST_SETTLE;
                end
            end
            // First settle cycle is the receiver reset pulse; the settle count starts after it.
            ST_SETTLE, ST_RETRY_SETTLE: begin
                if (dai_rst_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end else if (tmr_zero) begin
                    state_d   = (state_q == ST_SETTLE) ? ST_PROBE : ST_RETRY_PROBE;
                    ack_cnt_d = '0;
                    tmr_load  = 1'b1;
                    tmr_val   = PROBE_LD;
                end
            end
            ST_PROBE, ST_RETRY_PROBE: begin
                ack_cnt_d = ack_next;
                if (tmr_zero) begin
                    if ((ack_next == ACK_SAT) && dai_locked_i) begin
                        state_d  = ST_LOCKED;
                        tmr_load = 1'b1;
                        tmr_val  = WDOG_LD;
                    end else begin
                        state_d     = ST_SETTLE;
                        cph_d       = cph_adv;
                        scan_wrap_d = at_max;
                    end
                end
            end
            // An ack landing on the expiry cycle still refreshes the watchdog.
            ST_LOCKED: begin
                if (!dai_locked_i || (tmr_zero && !dai_ack_i)) begin
                    state_d  = ST_RETRY_SETTLE;
                    relock_d = 1'b1;
                end else if (dai_ack_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = WDOG_LD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!enable_i) begin
            state_d     = ST_IDLE;
            cph_d       = cph_q;
            scan_wrap_d = 1'b0;
            relock_d    = 1'b0;
        end

        dai_rst_d = (state_d != state_q) &&
                    ((state_d == ST_SETTLE) || (state_d == ST_RETRY_SETTLE));
        lock_d    = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cph_q       <= CPH_LO;
            ack_cnt_q   <= '0;
            dai_rst_q   <= 1'b1;
            lock_q      <= 1'b0;
            scan_wrap_q <= 1'b0;
            relock_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cph_q       <= cph_d;
            ack_cnt_q   <= ack_cnt_d;
            dai_rst_q   <= dai_rst_d;
            lock_q      <= lock_d;
            scan_wrap_q <= scan_wrap_d;
            relock_q    <= relock_d;
        end
    end

    assign clk_per_halfbit_o = cph_q;
    assign dai_rst_o         = dai_rst_q;
    assign lock_o            = lock_q;
    assign scan_wrap_o       = scan_wrap_q;
    assign relock_o          = relock_q;

endmodule

// File: tb/tb_spdif_lock_ctrl.sv
// Randomized bench: an attempt-level model predicts the output event stream; a negedge monitor compares.
module tb_spdif_lock_ctrl;

    localparam int S    = 16;
    localparam int P    = 64;
    localparam int NA   = 4;
    localparam int WD   = 32;
    localparam int CMIN = 3;
    localparam int CMAX = 6;
    localparam int NMAX = 1100;
    localparam int NSC  = 14;

    localparam int K_DN     = 0;
    localparam int K_RELOCK = 1;
    localparam int K_WRAP   = 2;
    localparam int K_RST    = 3;
    localparam int K_UP     = 4;

    typedef struct {
        int cyc;
        int kind;
        int cph;
    } ev_t;

    logic       clk          = 1'b0;
    logic       rst          = 1'b0;
    logic       enable_i     = 1'b0;
    logic       dai_locked_i = 1'b0;
    logic       dai_ack_i    = 1'b0;
    logic [4:0] clk_per_halfbit_o;
    logic       dai_rst_o;
    logic       lock_o;
    logic       scan_wrap_o;
    logic       relock_o;

    spdif_lock_ctrl #(
        .MAX_CLK_PER_HALFBIT_LOG2 (5),
        .CPH_MIN                  (CMIN),
        .CPH_MAX                  (CMAX),
        .TIMER_W                  (16),
        .SETTLE_CYCLES            (S),
        .PROBE_CYCLES             (P),
        .MIN_ACKS                 (NA),
        .WATCHDOG_CYCLES          (WD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable_i          (enable_i),
        .dai_locked_i      (dai_locked_i),
        .dai_ack_i         (dai_ack_i),
        .clk_per_halfbit_o (clk_per_halfbit_o),
        .dai_rst_o         (dai_rst_o),
        .lock_o            (lock_o),
        .scan_wrap_o       (scan_wrap_o),
        .relock_o          (relock_o)
    );

    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;
    ev_t exp_q[$];
    bit  ack_a[NMAX];
    bit  en_a[NMAX];
    int  good;
    int  drop_c;
    int  horizon;
    int  cyc      = -1;
    int  first_up = -1;
    bit  mon_on   = 1'b0;
    bit  prev_lock = 1'b0;

    // Receiver stand-in: locks only at its one good period and only before the drop cycle.
    function automatic bit rx_locked(int c, int cph);
        return (cph == good) && (c < drop_c);
    endfunction

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic void push(int c, int kind, int cph);
        if (c < horizon) exp_q.push_back('{c, kind, cph});
    endfunction

    function automatic void got(int kind, int cph);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event: unexpected kind=%0d cph=%0d at cycle %0d", kind, cph, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.kind != kind || e.cph != cph) begin
            failures++;
            $display("FAIL event: got kind=%0d cph=%0d at cycle %0d, expected kind=%0d cph=%0d at cycle %0d",
                     kind, cph, cyc, e.kind, e.cph, e.cyc);
        end
    endfunction

    // Walks whole attempts: each is one reset cycle, S settle cycles and a P-cycle ack window.
    task automatic build_model();
        int cph  = CMIN;
        int t    = 0;
        int s    = 0;
        int e    = 0;
        int n    = 0;
        int last = 0;
        int c    = 0;
        bit idle = 1'b1;
        bit done = 1'b0;
        exp_q.delete();
        while (!done) begin
            if (idle) begin
                while (t < horizon && !en_a[t]) t++;
                if (t >= horizon) done = 1'b1;
                else begin
                    s    = t + 1;
                    idle = 1'b0;
                end
            end else if (s >= horizon) begin
                done = 1'b1;
            end else begin
                push(s, K_RST, cph);
                e = s + S + P;
                c = s;
                while (c <= e && en_a[c]) c++;
                if (c <= e) begin
                    t    = c + 1;
                    idle = 1'b1;
                end else begin
                    n = 0;
                    for (int i = s + S + 1; i <= e; i++) n += int'(ack_a[i]);
                    if (n >= NA && rx_locked(e, cph)) begin
                        push(e + 1, K_UP, cph);
                        last = e;
                        c    = e + 1;
                        while (c < horizon && en_a[c] && rx_locked(c, cph) &&
                               !((c - last >= WD) && !ack_a[c])) begin
                            if (ack_a[c]) last = c;
                            c++;
                        end
                        if (c >= horizon) done = 1'b1;
                        else begin
                            push(c + 1, K_DN, 0);
                            if (!en_a[c]) begin
                                t    = c + 1;
                                idle = 1'b1;
                            end else begin
                                push(c + 1, K_RELOCK, 0);
                                s = c + 1;
                            end
                        end
                    end else begin
                        if (cph == CMAX) begin
                            cph = CMIN;
                            push(e + 1, K_WRAP, 0);
                        end else begin
                            cph++;
                        end
                        s = e + 1;
                    end
                end
            end
        end
    endtask

    task automatic setup(int sc);
        int ap;
        int off_s;
        int off_l;
        int en_s;
        for (int c = 0; c < NMAX; c++) begin
            ack_a[c] = 1'b0;
            en_a[c]  = 1'b1;
        end
        good    = 0;
        drop_c  = NMAX;
        horizon = 400;
        case (sc)
            0: begin
                good = 5;
                for (int c = 0; c < NMAX; c++) ack_a[c] = (c % 10 == 0);
            end
            1: begin
                horizon = 420;
                for (int c = 0; c < NMAX; c++) ack_a[c] = (c % 10 == 0);
            end
            2: begin
                good    = 5;
                horizon = 480;
                for (int c = 0; c < NMAX; c++) ack_a[c] = (c % 10 == 0) && (c < 300 || c >= 360);
            end
            3: begin
                good    = 5;
                drop_c  = 300;
                horizon = 600;
                for (int c = 0; c < NMAX; c++) ack_a[c] = (c % 10 == 0);
            end
            4: begin
                good     = 3;
                horizon  = 200;
                ack_a[30] = 1'b1;
                ack_a[40] = 1'b1;
                ack_a[50] = 1'b1;
                ack_a[81] = 1'b1;
            end
            5: begin
                good     = 3;
                horizon  = 200;
                ack_a[17] = 1'b1;
                ack_a[30] = 1'b1;
                ack_a[40] = 1'b1;
                ack_a[50] = 1'b1;
                ack_a[82] = 1'b1;
            end
            6: begin
                horizon = 250;
                for (int c = 0; c < NMAX; c++) ack_a[c] = (c % 10 == 0);
                for (int c = 50; c < 55; c++) en_a[c] = 1'b0;
            end
            7: begin
                good    = 3;
                horizon = 300;
                for (int c = 0; c < NMAX; c++) ack_a[c] = (c % 7 == 0);
                for (int c = 100; c < 104; c++) en_a[c] = 1'b0;
            end
            default: begin
                good    = $urandom_range(6, 2);
                drop_c  = $urandom_range(900, 150);
                ap      = $urandom_range(14, 3);
                horizon = 700;
                for (int c = 0; c < NMAX; c++) ack_a[c] = ($urandom_range(ap, 0) == 0);
                en_s  = $urandom_range(3, 0);
                off_s = $urandom_range(650, 0);
                off_l = $urandom_range(6, 0);
                for (int c = 0; c < en_s; c++) en_a[c] = 1'b0;
                for (int c = off_s; c < off_s + off_l; c++) en_a[c] = 1'b0;
            end
        endcase
    endtask

    task automatic run_scenario(int sc);
        setup(sc);
        build_model();
        first_up = -1;
        @(negedge clk);
        rst          = 1'b0;
        enable_i     = 1'b0;
        dai_ack_i    = 1'b0;
        dai_locked_i = 1'b0;
        #1;
        check("reset dai_rst_o", int'(dai_rst_o), 1);
        check("reset lock_o", int'(lock_o), 0);
        check("reset scan_wrap_o", int'(scan_wrap_o), 0);
        check("reset relock_o", int'(relock_o), 0);
        check("reset clk_per_halfbit_o", int'(clk_per_halfbit_o), CMIN);
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        prev_lock = 1'b0;
        for (int c = 0; c < horizon; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (c == 0) begin
                check("dai_rst_o after release", int'(dai_rst_o), 0);
                mon_on = 1'b1;
            end
            enable_i     = en_a[c];
            dai_ack_i    = ack_a[c];
            dai_locked_i = rx_locked(c, int'(clk_per_halfbit_o));
        end
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        check("pending events", exp_q.size(), 0);
        if (sc == 0) check("first lock cycle", first_up, 1 + 3 * (1 + S + P));
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_lock && !lock_o) got(K_DN, 0);
            if (relock_o) got(K_RELOCK, 0);
            if (scan_wrap_o) got(K_WRAP, 0);
            if (dai_rst_o) got(K_RST, int'(clk_per_halfbit_o));
            if (!prev_lock && lock_o) begin
                got(K_UP, int'(clk_per_halfbit_o));
                if (first_up < 0) first_up = cyc;
            end
            prev_lock = lock_o;
        end
    end

    initial begin
        for (int sc = 0; sc < NSC; sc++) run_scenario(sc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
